ocx_tlx_rcv_err_log: RTL and testbench
======================================

OCX_TLX_RCV_ERR_LOG -- requirements
Module: ocx_tlx_rcv_err_log

Interface
REQ-001 Parameter LOG_DEPTH, default 4, number of error-log FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter CNT_WIDTH, default 16, width of the error event counter.
REQ-003 tlx_clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rcv_xmt_debug_info  input  32  parser error report: [3:0] error code 1..7, [31:4] error context.
REQ-006 rcv_xmt_debug_valid  input  1  one-cycle qualifier for rcv_xmt_debug_info.
REQ-007 rcv_xmt_debug_fatal  input  1  report is fatal; meaningful only with valid.
REQ-008 err_clear  input  1  single-cycle clear of summary state (first error, count, code map, overflow).
REQ-009 log_rd_req  input  1  pop request for the oldest logged report.
REQ-010 log_rd_valid  output  1  log_rd_data valid, one cycle per accepted pop.
REQ-011 log_rd_data  output  32  popped report, unmodified rcv_xmt_debug_info.
REQ-012 log_empty / log_full  output  1 each  FIFO occupancy flags.
REQ-013 first_err_valid  output  1  first report since last clear/reset is held.
REQ-014 first_err_info  output  32  held first report.
REQ-015 err_code_seen  output  8  sticky map: bit k set for code k (1..7); bit 0 for code 0 or 8..15.
REQ-016 err_count  output  CNT_WIDTH  saturating count of valid reports.
REQ-017 log_overflow  output  1  sticky: a report was dropped because the FIFO was full.
REQ-018 fatal_irq  output  1  level: a fatal report has been seen since last clear/reset.

Function
REQ-019 A report SHALL be accepted on every rising edge where rcv_xmt_debug_valid=1; no back-pressure exists.
REQ-020 On acceptance the FIFO write, count, code map and first-error capture SHALL all be visible on outputs the cycle after the accepting edge.
REQ-021 first_err_info SHALL load only when first_err_valid=0 at the accepting edge; later reports SHALL NOT alter it.
REQ-022 err_count SHALL increment by 1 per accepted report and hold at all-ones (no wrap).
REQ-023 fatal_irq SHALL set on any accepted report with rcv_xmt_debug_fatal=1 and hold until err_clear or reset.
REQ-024 FIFO: write pointer, read pointer, occupancy counter 0..LOG_DEPTH; log_empty = (occupancy==0), log_full = (occupancy==LOG_DEPTH).
REQ-025 Pop accepted when log_rd_req=1 and log_empty=0 at the edge; log_rd_valid=1 and log_rd_data=oldest entry in the following cycle; otherwise log_rd_valid=0.
REQ-026 log_rd_req while empty SHALL be ignored (no pointer movement, log_rd_valid=0), including when a write arrives the same edge.
REQ-027 Write while full without a same-edge pop SHALL drop the report from the FIFO, set log_overflow; count, code map, first error and fatal_irq still update.
REQ-028 Write and pop on the same edge while full SHALL both be accepted; occupancy unchanged.
REQ-029 Pointers SHALL wrap modulo LOG_DEPTH.
REQ-030 err_clear SHALL zero first_err_valid, first_err_info, err_code_seen, err_count, log_overflow, fatal_irq; FIFO contents and pointers SHALL be untouched.
REQ-031 err_clear and valid on the same edge: report wins -- first_err_valid=1 holding that report, err_count=1, code map/fatal_irq reflect only that report.
REQ-032 log_rd_data SHALL hold its last value when log_rd_valid=0.

Reset
REQ-033 While reset=1 at an edge: all outputs 0 except log_empty=1; FIFO pointers and occupancy 0; in-flight pop discarded (log_rd_valid=0 next cycle).
REQ-034 Inputs sampled during reset SHALL be ignored; the first report is accepted on the first edge with reset=0.

Verification
REQ-035 Single report info=0x0000_1235, fatal=1 -> next cycle first_err_info=0x0000_1235, err_code_seen=0x20, err_count=1, fatal_irq=1, log_empty=0.
REQ-036 Five back-to-back reports codes 1..5, no pops (LOG_DEPTH=4) -> log_full=1, log_overflow=1, err_count=5, pops return codes 1,2,3,4 then log_empty=1.
REQ-037 FIFO full, write code 7 and pop same edge -> log_rd_data=code-1 entry, occupancy stays 4, log_overflow=0.
REQ-038 err_clear with valid code 6 same edge -> first_err_info code 6, err_count=1, err_code_seen=0x40, FIFO entries retained.
REQ-039 CNT_WIDTH=4, 20 reports -> err_count=0xF, no wrap.
REQ-040 reset asserted with 3 entries and a pop in flight -> log_rd_valid=0, log_empty=1, all summary outputs 0 next cycle.

Source files
------------

// File: rtl/ocx_tlx_rcv_err_log_if.sv
// Parser error-report and log-read bundle between the TLX receive parser side and the
// error logger.
interface ocx_tlx_rcv_err_log_if;
  logic [31:0] rcv_xmt_debug_info;
  logic        rcv_xmt_debug_valid;
  logic        rcv_xmt_debug_fatal;
  logic        log_rd_req;
  logic        log_rd_valid;
  logic [31:0] log_rd_data;
  logic        log_empty;
  logic        log_full;

  modport master (
    output rcv_xmt_debug_info,
    output rcv_xmt_debug_valid,
    output rcv_xmt_debug_fatal,
    output log_rd_req,
    input  log_rd_valid,
    input  log_rd_data,
    input  log_empty,
    input  log_full
  );

  modport slave (
    input  rcv_xmt_debug_info,
    input  rcv_xmt_debug_valid,
    input  rcv_xmt_debug_fatal,
    input  log_rd_req,
    output log_rd_valid,
    output log_rd_data,
    output log_empty,
    output log_full
  );
endinterface

// File: rtl/ocx_tlx_rcv_err_log.sv
// TLX receive error logger: FIFO of raw parser error reports plus sticky summary state
// (first error, saturating count, code map, overflow, fatal interrupt).
module ocx_tlx_rcv_err_log #(
  parameter int unsigned LOG_DEPTH = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 tlx_clk,
  input  logic                 reset,
  input  logic                 err_clear,
  ocx_tlx_rcv_err_log_if.slave rcv_if,
  output logic                 first_err_valid,
  output logic [31:0]          first_err_info,
  output logic [7:0]           err_code_seen,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 log_overflow,
  output logic                 fatal_irq
);

  localparam int unsigned PtrW = $clog2(LOG_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [OccW-1:0] OccOne  = OccW'(1);
  localparam logic [OccW-1:0] OccFull = OccW'(LOG_DEPTH);

  logic [31:0]          mem_q [LOG_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 first_valid_q, first_valid_d;
  logic [31:0]          first_info_q, first_info_d;
  logic [7:0]           code_seen_q, code_seen_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 fatal_q, fatal_d;

  logic                 empty, full, rpt, push, pop, drop;
  logic [3:0]           code;
  logic [7:0]           code_bit;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OccFull);
  assign rpt   = rcv_if.rcv_xmt_debug_valid;
  assign pop   = rcv_if.log_rd_req && !empty;
  // A full FIFO still takes a write when the same edge frees a slot.
  assign push  = rpt && (!full || pop);
  assign drop  = rpt && full && !pop;
  assign code  = rcv_if.rcv_xmt_debug_info[3:0];

  always_comb begin
    code_bit = 8'h01;
    if (code >= 4'd1 && code <= 4'd7) begin
      code_bit = 8'h01 << code[2:0];
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rd_valid_d = pop;
    rd_data_d  = rd_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PtrOne;
      rd_data_d = mem_q[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase
  end

  // Clear is applied first so a same-edge report lands on a freshly cleared summary.
  always_comb begin
    first_valid_d = err_clear ? 1'b0  : first_valid_q;
    first_info_d  = err_clear ? '0    : first_info_q;
    code_seen_d   = err_clear ? 8'h00 : code_seen_q;
    count_d       = err_clear ? '0    : count_q;
    overflow_d    = err_clear ? 1'b0  : overflow_q;
    fatal_d       = err_clear ? 1'b0  : fatal_q;
    if (rpt) begin
      if (!first_valid_d) begin
        first_valid_d = 1'b1;
        first_info_d  = rcv_if.rcv_xmt_debug_info;
      end
      code_seen_d = code_seen_d | code_bit;
      if (count_d != '1) begin
        count_d = count_d + CNT_WIDTH'(1);
      end
      fatal_d = fatal_d | rcv_if.rcv_xmt_debug_fatal;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge tlx_clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      first_valid_q <= 1'b0;
      first_info_q  <= '0;
      code_seen_q   <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      first_valid_q <= first_valid_d;
      first_info_q  <= first_info_d;
      code_seen_q   <= code_seen_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      fatal_q       <= fatal_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge tlx_clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= rcv_if.rcv_xmt_debug_info;
    end
  end

  assign rcv_if.log_rd_valid = rd_valid_q;
  assign rcv_if.log_rd_data  = rd_data_q;
  assign rcv_if.log_empty    = empty;
  assign rcv_if.log_full     = full;

  assign first_err_valid = first_valid_q;
  assign first_err_info  = first_info_q;
  assign err_code_seen   = code_seen_q;
  assign err_count       = count_q;
  assign log_overflow    = overflow_q;
  assign fatal_irq       = fatal_q;

endmodule

// File: tb/tb_ocx_tlx_rcv_err_log.sv
// Directed bench for ocx_tlx_rcv_err_log; a second instance with CNT_WIDTH=4 shares the
// stimulus to check counter saturation.
module tb_ocx_tlx_rcv_err_log;
  logic tlx_clk = 1'b0;
  logic reset;
  logic err_clear;

  ocx_tlx_rcv_err_log_if bus ();
  ocx_tlx_rcv_err_log_if bus4 ();

  logic        first_err_valid;
  logic [31:0] first_err_info;
  logic [7:0]  err_code_seen;
  logic [15:0] err_count;
  logic        log_overflow;
  logic        fatal_irq;

  logic        first_err_valid4;
  logic [31:0] first_err_info4;
  logic [7:0]  err_code_seen4;
  logic [3:0]  err_count4;
  logic        log_overflow4;
  logic        fatal_irq4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 tlx_clk = ~tlx_clk;

  assign bus4.rcv_xmt_debug_info  = bus.rcv_xmt_debug_info;
  assign bus4.rcv_xmt_debug_valid = bus.rcv_xmt_debug_valid;
  assign bus4.rcv_xmt_debug_fatal = bus.rcv_xmt_debug_fatal;
  assign bus4.log_rd_req          = bus.log_rd_req;

  ocx_tlx_rcv_err_log #(.LOG_DEPTH(4), .CNT_WIDTH(16)) u_dut (
    .tlx_clk         (tlx_clk),
    .reset           (reset),
    .err_clear       (err_clear),
    .rcv_if          (bus.slave),
    .first_err_valid (first_err_valid),
    .first_err_info  (first_err_info),
    .err_code_seen   (err_code_seen),
    .err_count       (err_count),
    .log_overflow    (log_overflow),
    .fatal_irq       (fatal_irq)
  );

  ocx_tlx_rcv_err_log #(.LOG_DEPTH(4), .CNT_WIDTH(4)) u_dut4 (
    .tlx_clk         (tlx_clk),
    .reset           (reset),
    .err_clear       (err_clear),
    .rcv_if          (bus4.slave),
    .first_err_valid (first_err_valid4),
    .first_err_info  (first_err_info4),
    .err_code_seen   (err_code_seen4),
    .err_count       (err_count4),
    .log_overflow    (log_overflow4),
    .fatal_irq       (fatal_irq4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] info, input logic fatal);
    bus.rcv_xmt_debug_info  = info;
    bus.rcv_xmt_debug_valid = 1'b1;
    bus.rcv_xmt_debug_fatal = fatal;
    tick();
    bus.rcv_xmt_debug_valid = 1'b0;
    bus.rcv_xmt_debug_fatal = 1'b0;
  endtask

  task automatic pop_one();
    bus.log_rd_req = 1'b1;
    tick();
    bus.log_rd_req = 1'b0;
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pops [4];
    reset                   = 1'b1;
    err_clear               = 1'b0;
    bus.rcv_xmt_debug_info  = 32'h0000_0777;
    bus.rcv_xmt_debug_valid = 1'b1;
    bus.rcv_xmt_debug_fatal = 1'b1;
    bus.log_rd_req          = 1'b1;
    tick();
    tick();
    // Inputs offered during reset must leave no trace.
    check_eq("rst_empty", 32'(bus.log_empty), 32'd1);
    check_eq("rst_full", 32'(bus.log_full), 32'd0);
    check_eq("rst_rd_valid", 32'(bus.log_rd_valid), 32'd0);
    check_eq("rst_rd_data", bus.log_rd_data, 32'd0);
    check_eq("rst_first_valid", 32'(first_err_valid), 32'd0);
    check_eq("rst_count", 32'(err_count), 32'd0);
    check_eq("rst_code_seen", 32'(err_code_seen), 32'd0);
    check_eq("rst_fatal", 32'(fatal_irq), 32'd0);
    reset                   = 1'b0;
    bus.rcv_xmt_debug_valid = 1'b0;
    bus.rcv_xmt_debug_fatal = 1'b0;
    bus.log_rd_req          = 1'b0;
    tick();

    // Single fatal report.
    send(32'h0000_1235, 1'b1);
    check_eq("one_first_valid", 32'(first_err_valid), 32'd1);
    check_eq("one_first_info", first_err_info, 32'h0000_1235);
    check_eq("one_code_seen", 32'(err_code_seen), 32'h20);
    check_eq("one_count", 32'(err_count), 32'd1);
    check_eq("one_fatal", 32'(fatal_irq), 32'd1);
    check_eq("one_empty", 32'(bus.log_empty), 32'd0);
    pop_one();
    check_eq("one_pop_valid", 32'(bus.log_rd_valid), 32'd1);
    check_eq("one_pop_data", bus.log_rd_data, 32'h0000_1235);
    check_eq("one_pop_empty", 32'(bus.log_empty), 32'd1);
    tick();
    check_eq("idle_rd_valid", 32'(bus.log_rd_valid), 32'd0);
    check_eq("idle_rd_hold", bus.log_rd_data, 32'h0000_1235);

    clear_pulse();
    check_eq("clr_first_valid", 32'(first_err_valid), 32'd0);
    check_eq("clr_first_info", first_err_info, 32'd0);
    check_eq("clr_count", 32'(err_count), 32'd0);
    check_eq("clr_code_seen", 32'(err_code_seen), 32'd0);
    check_eq("clr_fatal", 32'(fatal_irq), 32'd0);

    // Five reports into a four-entry log.
    for (int k = 1; k <= 5; k++) begin
      send(32'h0000_0100 * k + k, 1'b0);
    end
    check_eq("five_full", 32'(bus.log_full), 32'd1);
    check_eq("five_overflow", 32'(log_overflow), 32'd1);
    check_eq("five_count", 32'(err_count), 32'd5);
    check_eq("five_code_seen", 32'(err_code_seen), 32'h3E);
    check_eq("five_first_info", first_err_info, 32'h0000_0101);
    check_eq("five_fatal", 32'(fatal_irq), 32'd0);

    clear_pulse();
    check_eq("clr2_overflow", 32'(log_overflow), 32'd0);
    check_eq("clr2_full_kept", 32'(bus.log_full), 32'd1);

    // Write and pop on the same edge while full.
    bus.log_rd_req = 1'b1;
    send(32'h0000_0707, 1'b0);
    bus.log_rd_req = 1'b0;
    check_eq("wp_rd_valid", 32'(bus.log_rd_valid), 32'd1);
    check_eq("wp_rd_data", bus.log_rd_data, 32'h0000_0101);
    check_eq("wp_full", 32'(bus.log_full), 32'd1);
    check_eq("wp_overflow", 32'(log_overflow), 32'd0);
    check_eq("wp_first_info", first_err_info, 32'h0000_0707);

    exp_pops[0] = 32'h0000_0202;
    exp_pops[1] = 32'h0000_0303;
    exp_pops[2] = 32'h0000_0404;
    exp_pops[3] = 32'h0000_0707;
    for (int i = 0; i < 4; i++) begin
      pop_one();
      check_eq($sformatf("drain%0d_valid", i), 32'(bus.log_rd_valid), 32'd1);
      check_eq($sformatf("drain%0d_data", i), bus.log_rd_data, exp_pops[i]);
    end
    check_eq("drain_empty", 32'(bus.log_empty), 32'd1);
    pop_one();
    check_eq("empty_pop_valid", 32'(bus.log_rd_valid), 32'd0);
    check_eq("empty_pop_hold", bus.log_rd_data, 32'h0000_0707);

    // Clear and report on the same edge: report wins.
    send(32'h0000_0111, 1'b1);
    err_clear = 1'b1;
    send(32'h0000_0606, 1'b0);
    err_clear = 1'b0;
    check_eq("cv_first_valid", 32'(first_err_valid), 32'd1);
    check_eq("cv_first_info", first_err_info, 32'h0000_0606);
    check_eq("cv_count", 32'(err_count), 32'd1);
    check_eq("cv_code_seen", 32'(err_code_seen), 32'h40);
    check_eq("cv_fatal", 32'(fatal_irq), 32'd0);
    pop_one();
    check_eq("cv_pop0", bus.log_rd_data, 32'h0000_0111);
    pop_one();
    check_eq("cv_pop1", bus.log_rd_data, 32'h0000_0606);
    check_eq("cv_empty", 32'(bus.log_empty), 32'd1);

    // Pop request while empty with a same-edge write is ignored; the write lands.
    bus.log_rd_req = 1'b1;
    send(32'h0000_0300, 1'b0);
    bus.log_rd_req = 1'b0;
    check_eq("ew_rd_valid", 32'(bus.log_rd_valid), 32'd0);
    check_eq("ew_empty", 32'(bus.log_empty), 32'd0);
    check_eq("ew_code0", 32'(err_code_seen), 32'h41);
    pop_one();
    check_eq("ew_pop_data", bus.log_rd_data, 32'h0000_0300);

    // Counter saturation on the narrow instance.
    clear_pulse();
    for (int k = 0; k < 20; k++) begin
      send(32'h0000_0002, 1'b0);
    end
    check_eq("sat_count4", 32'(err_count4), 32'hF);
    check_eq("sat_count16", 32'(err_count), 32'd20);

    // Reset with three entries and a pop in flight.
    pop_one();
    bus.log_rd_req = 1'b1;
    reset          = 1'b1;
    tick();
    bus.log_rd_req = 1'b0;
    check_eq("rst2_rd_valid", 32'(bus.log_rd_valid), 32'd0);
    check_eq("rst2_rd_data", bus.log_rd_data, 32'd0);
    check_eq("rst2_empty", 32'(bus.log_empty), 32'd1);
    check_eq("rst2_count", 32'(err_count), 32'd0);
    check_eq("rst2_code_seen", 32'(err_code_seen), 32'd0);
    check_eq("rst2_overflow", 32'(log_overflow), 32'd0);
    check_eq("rst2_first_valid", 32'(first_err_valid), 32'd0);
    check_eq("rst2_count4", 32'(err_count4), 32'd0);
    reset = 1'b0;
    send(32'h0000_1232, 1'b0);
    check_eq("post_rst_count", 32'(err_count), 32'd1);
    check_eq("post_rst_code", 32'(err_code_seen), 32'h04);
    check_eq("post_rst_first", first_err_info, 32'h0000_1232);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
